// File: rtl/uart_aes_loader.sv
// Receives an 8N1 command frame ('E'/'D' + 16 key bytes + 16 data bytes) over UART
// and launches the AES core with a one-cycle start pulse once the core is ready.
module uart_aes_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_CLKS = 10_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         uart_rx,
  input  logic         core_ready,
  output logic         start,
  output logic         enc_dec,
  output logic [127:0] key_out,
  output logic [127:0] data_out,
  output logic         busy,
  output logic         frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CLKS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {F_CMD, F_KEY, F_DATA, F_WAIT_READY} frame_state_t;

  logic          rx_meta, rx_sync, rx_prev;
  rx_state_t     rx_state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg, rx_byte;
  logic          byte_valid, ferr;

  frame_state_t  f_state;
  logic [127:0]  key_asm, data_asm;
  logic          mode_pend;
  logic [3:0]    byte_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          in_frame, timeout;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      ferr       <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      ferr       <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            clk_cnt  <= '0;
          end
        end
        RX_START: begin
          if (clk_cnt == HALF_CNT) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            if (rx_sync) rx_state <= RX_IDLE;
            else         rx_state <= RX_BITS;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_BITS: begin
          if (clk_cnt == FULL_CNT) begin
            clk_cnt   <= '0;
            shift_reg <= {rx_sync, shift_reg[7:1]};
            bit_idx   <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (clk_cnt == FULL_CNT) begin
            clk_cnt  <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              rx_byte    <= shift_reg;
            end else begin
              ferr <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // A byte arriving in the same cycle as the timeout suppresses the abort
  assign in_frame = (f_state == F_KEY) || (f_state == F_DATA);
  assign timeout  = in_frame && (tmo_cnt == TMO_MAX) && !byte_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (byte_valid) begin
      tmo_cnt <= '0;
    end else if (in_frame && (tmo_cnt != TMO_MAX)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_state   <= F_CMD;
      key_asm   <= '0;
      data_asm  <= '0;
      mode_pend <= 1'b1;
      byte_cnt  <= '0;
      start     <= 1'b0;
      enc_dec   <= 1'b1;
      key_out   <= '0;
      data_out  <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      start <= 1'b0;
      case (f_state)
        F_CMD: begin
          busy <= 1'b0;
          if (ferr) frame_err <= 1'b1;
          if (byte_valid && ((rx_byte == 8'h45) || (rx_byte == 8'h44))) begin
            // 'E' (0x45) and 'D' (0x44) differ only in bit 0
            mode_pend <= rx_byte[0];
            frame_err <= 1'b0;
            byte_cnt  <= '0;
            busy      <= 1'b1;
            f_state   <= F_KEY;
          end
        end
        F_KEY, F_DATA: begin
          if (ferr || timeout) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            f_state   <= F_CMD;
          end else if (byte_valid) begin
            byte_cnt <= byte_cnt + 1'b1;
            if (f_state == F_KEY) key_asm  <= {key_asm[119:0], rx_byte};
            else                  data_asm <= {data_asm[119:0], rx_byte};
            if (byte_cnt == 4'd15) begin
              if (f_state == F_KEY) f_state <= F_DATA;
              else                  f_state <= F_WAIT_READY;
            end
          end
        end
        F_WAIT_READY: begin
          if (byte_valid) frame_err <= 1'b1;
          if (core_ready) begin
            key_out  <= key_asm;
            data_out <= data_asm;
            enc_dec  <= mode_pend;
            start    <= 1'b1;
            f_state  <= F_CMD;
          end
        end
        default: f_state <= F_CMD;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_aes_loader.sv
// Self-checking bench for uart_aes_loader: drives UART frames and compares launches
// against a byte-stream frame parser kept in the bench.
module tb_uart_aes_loader;
  localparam int CPB = 8;
  localparam int TMO = 2000;

  logic         clk = 1'b0;
  logic         rst_n, uart_rx, core_ready;
  logic         start, enc_dec, busy, frame_err;
  logic [127:0] key_out, data_out;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int start_count = 0;
  int last_bv_cyc = 0;
  int last_start_cyc = 0;
  int byte_start_cyc = 0;

  int           model_q[$];
  logic         exp_ok;
  logic         exp_mode = 1'b1;
  logic [255:0] exp_kd = '0;

  uart_aes_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .core_ready(core_ready),
    .start(start), .enc_dec(enc_dec), .key_out(key_out), .data_out(data_out),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Pulse monitor sampled 2 ns after each rising edge
  always @(posedge clk) begin
    #2;
    if (dut.byte_valid) last_bv_cyc = cyc;
    if (start) begin
      start_count++;
      last_start_cyc = cyc;
    end
  end

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [7:0] cmd, input logic [255:0] kd, input int j);
    if (j == 0) return cmd;
    return kd[263 - 8*j -: 8];
  endfunction

  // Frame parser over everything sent: a command byte opens a 32-byte frame, -1/-2 markers abort it
  task automatic model_expect();
    int need;
    int v;
    logic [255:0] kd;
    logic mode;
    need = 0;
    kd = '0;
    mode = 1'b1;
    exp_ok = 1'b0;
    foreach (model_q[i]) begin
      v = model_q[i];
      if (!exp_ok) begin
        if (need == 0) begin
          if (v == 'h45 || v == 'h44) begin
            mode = (v == 'h45);
            need = 32;
          end
        end else if (v < 0) begin
          need = 0;
        end else begin
          kd = {kd[247:0], v[7:0]};
          need--;
          if (need == 0) begin
            exp_ok = 1'b1;
            exp_kd = kd;
            exp_mode = mode;
          end
        end
      end
    end
    model_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    @(negedge clk);
    byte_start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
    if (stop_bit) model_q.push_back(int'(b));
    else          model_q.push_back(-1);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [255:0] kd, input int first, input int last, input int bad);
    for (int j = first; j <= last; j++) send_byte(frame_byte(cmd, kd, j), j != bad);
  endtask

  task automatic glitch();
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({start, enc_dec, busy, frame_err} !== 4'b0100) $display("[TB] FAIL reset_flags: got %b expected 0100", {start, enc_dec, busy, frame_err}); else passes++;
    checks++; if ({key_out, data_out} !== 256'd0) $display("[TB] FAIL reset_operands: got %h expected 0", {key_out, data_out}); else passes++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_encrypt_fixed();
    logic [255:0] kd;
    int s0;
    int lat;
    kd = {128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff};
    model_q.delete();
    s0 = start_count;
    send_frame(8'h45, kd, 0, 32, -1);
    @(negedge clk);
    checks++; if ({start, busy} !== 2'b11) $display("[TB] FAIL enc_pulse_cycle: got start,busy=%b expected 11", {start, busy}); else passes++;
    @(negedge clk);
    checks++; if ({start, busy} !== 2'b00) $display("[TB] FAIL enc_after_pulse: got start,busy=%b expected 00", {start, busy}); else passes++;
    repeat (3) @(negedge clk);
    checks++; if (start_count - s0 != 1) $display("[TB] FAIL enc_start_count: got %0d expected 1", start_count - s0); else passes++;
    checks++; if (last_start_cyc - last_bv_cyc != 2) $display("[TB] FAIL enc_start_latency: got %0d expected 2", last_start_cyc - last_bv_cyc); else passes++;
    lat = last_start_cyc - byte_start_cyc;
    checks++; if (lat > 10*CPB + 3 || lat < 9*CPB) $display("[TB] FAIL enc_last_byte_latency: got %0d expected %0d..%0d", lat, 9*CPB, 10*CPB + 3); else passes++;
    model_expect();
    checks++; if (!exp_ok || {enc_dec, key_out, data_out} !== {exp_mode, exp_kd}) $display("[TB] FAIL enc_operands: got %b %h expected %b %h", enc_dec, {key_out, data_out}, exp_mode, exp_kd); else passes++;
  endtask

  task automatic test_wait_ready();
    logic [255:0] kd;
    int s0;
    kd = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734};
    core_ready = 1'b0;
    s0 = start_count;
    send_frame(8'h44, kd, 0, 32, -1);
    repeat (200) @(negedge clk);
    checks++; if (start_count != s0) $display("[TB] FAIL wait_no_start: got %0d pulses expected 0", start_count - s0); else passes++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL wait_busy: got %b expected 1", busy); else passes++;
    checks++; if ({enc_dec, key_out, data_out} !== {exp_mode, exp_kd}) $display("[TB] FAIL wait_outputs_held: got %b %h expected %b %h", enc_dec, {key_out, data_out}, exp_mode, exp_kd); else passes++;
    core_ready = 1'b1;
    @(negedge clk);
    checks++; if (start !== 1'b1) $display("[TB] FAIL wait_start_on_ready: got %b expected 1", start); else passes++;
    model_expect();
    checks++; if (!exp_ok || {enc_dec, key_out, data_out} !== {exp_mode, exp_kd}) $display("[TB] FAIL wait_operands: got %b %h expected %b %h", enc_dec, {key_out, data_out}, exp_mode, exp_kd); else passes++;
    repeat (3) @(negedge clk);
    checks++; if (start_count - s0 != 1) $display("[TB] FAIL wait_start_count: got %0d expected 1", start_count - s0); else passes++;
  endtask

  task automatic test_stop_error();
    logic [255:0] kd;
    int s0;
    model_q.delete();
    s0 = start_count;
    kd = rand256();
    send_frame(8'h45, kd, 0, 5, 5);
    repeat (20) @(negedge clk);
    checks++; if ({frame_err, busy} !== 2'b10) $display("[TB] FAIL stoperr_abort: got err,busy=%b expected 10", {frame_err, busy}); else passes++;
    kd = rand256();
    send_frame(8'h45, kd, 0, 0, -1);
    checks++; if ({frame_err, busy} !== 2'b01) $display("[TB] FAIL stoperr_cmd_clears: got err,busy=%b expected 01", {frame_err, busy}); else passes++;
    send_frame(8'h45, kd, 1, 32, -1);
    repeat (4) @(negedge clk);
    checks++; if (start_count - s0 != 1) $display("[TB] FAIL stoperr_start_count: got %0d expected 1", start_count - s0); else passes++;
    model_expect();
    checks++; if (!exp_ok || {enc_dec, key_out, data_out} !== {exp_mode, exp_kd}) $display("[TB] FAIL stoperr_operands: got %b %h expected %b %h", enc_dec, {key_out, data_out}, exp_mode, exp_kd); else passes++;
  endtask

  task automatic test_junk();
    logic [255:0] kd;
    int s0;
    model_q.delete();
    s0 = start_count;
    send_byte(8'h00, 1'b1);
    send_byte(8'h41, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (5) @(negedge clk);
    checks++; if ({frame_err, busy} !== 2'b00) $display("[TB] FAIL junk_ignored: got err,busy=%b expected 00", {frame_err, busy}); else passes++;
    kd = rand256();
    send_frame(8'h45, kd, 0, 32, -1);
    repeat (4) @(negedge clk);
    checks++; if (start_count - s0 != 1) $display("[TB] FAIL junk_start_count: got %0d expected 1", start_count - s0); else passes++;
    model_expect();
    checks++; if (!exp_ok || {frame_err, enc_dec, key_out, data_out} !== {1'b0, exp_mode, exp_kd}) $display("[TB] FAIL junk_operands: got %b %b %h expected 0 %b %h", frame_err, enc_dec, {key_out, data_out}, exp_mode, exp_kd); else passes++;
  endtask

  task automatic test_glitch_timeout();
    logic [255:0] kd;
    int s0;
    model_q.delete();
    s0 = start_count;
    glitch();
    repeat (20) @(negedge clk);
    checks++; if ({frame_err, busy} !== 2'b00) $display("[TB] FAIL glitch_idle: got err,busy=%b expected 00", {frame_err, busy}); else passes++;
    kd = rand256();
    send_frame(8'h45, kd, 0, 3, -1);
    repeat (TMO - 10) @(negedge clk);
    checks++; if ({frame_err, busy} !== 2'b01) $display("[TB] FAIL timeout_not_yet: got err,busy=%b expected 01", {frame_err, busy}); else passes++;
    repeat (20) @(negedge clk);
    checks++; if ({frame_err, busy} !== 2'b10) $display("[TB] FAIL timeout_abort: got err,busy=%b expected 10", {frame_err, busy}); else passes++;
    checks++; if (start_count != s0) $display("[TB] FAIL timeout_no_start: got %0d pulses expected 0", start_count - s0); else passes++;
    model_q.push_back(-2);
  endtask

  task automatic test_overrun();
    logic [255:0] kd;
    logic [7:0] extra;
    int s0;
    model_q.delete();
    core_ready = 1'b0;
    s0 = start_count;
    kd = rand256();
    extra = 8'($urandom_range(0, 255));
    send_frame(8'h44, kd, 0, 32, -1);
    send_byte(extra, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if ({frame_err, busy} !== 2'b11) $display("[TB] FAIL overrun_flag: got err,busy=%b expected 11", {frame_err, busy}); else passes++;
    checks++; if (start_count != s0) $display("[TB] FAIL overrun_no_start: got %0d pulses expected 0", start_count - s0); else passes++;
    core_ready = 1'b1;
    @(negedge clk);
    checks++; if (start !== 1'b1) $display("[TB] FAIL overrun_launch: got %b expected 1", start); else passes++;
    model_expect();
    checks++; if (!exp_ok || {frame_err, enc_dec, key_out, data_out} !== {1'b1, exp_mode, exp_kd}) $display("[TB] FAIL overrun_operands: got %b %b %h expected 1 %b %h", frame_err, enc_dec, {key_out, data_out}, exp_mode, exp_kd); else passes++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [255:0] kd;
    logic [7:0] cmd;
    int s0;
    int g;
    for (int f = 0; f < 3; f++) begin
      model_q.delete();
      s0 = start_count;
      kd = rand256();
      cmd = ($urandom_range(0, 1) != 0) ? 8'h45 : 8'h44;
      g = $urandom_range(1, 32);
      send_frame(cmd, kd, 0, g - 1, -1);
      glitch();
      send_frame(cmd, kd, g, 32, -1);
      repeat (3) @(negedge clk);
      checks++; if (start_count - s0 != 1) $display("[TB] FAIL b2b_start_count[%0d]: got %0d expected 1", f, start_count - s0); else passes++;
      model_expect();
      checks++; if (!exp_ok || {frame_err, enc_dec, key_out, data_out} !== {1'b0, exp_mode, exp_kd}) $display("[TB] FAIL b2b_operands[%0d]: got %b %b %h expected 0 %b %h", f, frame_err, enc_dec, {key_out, data_out}, exp_mode, exp_kd); else passes++;
    end
  endtask

  task automatic test_async_reset();
    logic [255:0] kd;
    int s0;
    model_q.delete();
    kd = rand256();
    send_frame(8'h45, kd, 0, 22, -1);
    uart_rx = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({start, enc_dec, busy, frame_err} !== 4'b0100) $display("[TB] FAIL async_reset_flags: got %b expected 0100", {start, enc_dec, busy, frame_err}); else passes++;
    checks++; if ({key_out, data_out} !== 256'd0) $display("[TB] FAIL async_reset_operands: got %h expected 0", {key_out, data_out}); else passes++;
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    model_q.delete();
    s0 = start_count;
    kd = rand256();
    send_frame(8'h44, kd, 0, 32, -1);
    repeat (4) @(negedge clk);
    checks++; if (start_count - s0 != 1) $display("[TB] FAIL post_reset_start_count: got %0d expected 1", start_count - s0); else passes++;
    model_expect();
    checks++; if (!exp_ok || {frame_err, enc_dec, key_out, data_out} !== {1'b0, exp_mode, exp_kd}) $display("[TB] FAIL post_reset_operands: got %b %b %h expected 0 %b %h", frame_err, enc_dec, {key_out, data_out}, exp_mode, exp_kd); else passes++;
  endtask

  initial begin
    rst_n = 1'b0;
    uart_rx = 1'b1;
    core_ready = 1'b1;
    test_reset();
    test_encrypt_fixed();
    test_wait_ready();
    test_stop_error();
    test_junk();
    test_glitch_timeout();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/uart_aes_loader.md
# uart_aes_loader

Upstream feeder for the AES core on the FPGA board. It receives a framed command over a UART RX line (8N1) and assembles a 128-bit key and a 128-bit data block. When the core reports ready, it presents the operands with a one-cycle `start` pulse. This lets a host PC drive arbitrary vectors into the core instead of the fixed switch-selected set.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 868: clocks per UART bit (100 MHz / 115200). Minimum 4.
- `TIMEOUT_CLKS`, default 10_000_000: maximum idle clocks between bytes inside a frame.

Ports:
- `clk`, input, 1: system clock; the block has a single clock domain.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `uart_rx`, input, 1: serial line, idle high, asynchronous to `clk`.
- `core_ready`, input, 1: AES core ready/idle.
- `start`, output, 1: one-cycle launch pulse to the core.
- `enc_dec`, output, 1: 1 = encrypt, 0 = decrypt.
- `key_out`, output, 128: key operand.
- `data_out`, output, 128: data operand.
- `busy`, output, 1: frame in progress or waiting to launch.
- `frame_err`, output, 1: sticky error flag.

## Operation

- Reset values: `start` = 0, `enc_dec` = 1, `key_out` = 0, `data_out` = 0, `busy` = 0, `frame_err` = 0. The RX FSM goes to IDLE and the frame FSM goes to CMD.
- Reset mid-operation discards any partial byte and any partial frame.
- RX path:
  - `uart_rx` passes through a 2-flop synchronizer.
  - RX FSM states: IDLE, START, BITS, STOP.
  - IDLE → START on a synchronized high→low transition.
  - START: wait `CLKS_PER_BIT/2` (integer division). If the line is still low → BITS. If high → IDLE (false start, nothing reported).
  - BITS: sample 8 bits at `CLKS_PER_BIT` intervals, LSB first, then → STOP.
  - STOP: sample once at `CLKS_PER_BIT`. High → internal one-cycle `byte_valid` carrying the byte. Low → framing error: the byte is dropped and `ferr` pulses. Either way → IDLE.
- Frame FSM states: CMD, KEY, DATA, WAIT_READY.
  - CMD: 0x45 ('E') latches pending mode = 1; 0x44 ('D') latches pending mode = 0. Either clears `frame_err`, resets the byte counter and → KEY. Any other byte is ignored silently.
  - KEY: 16 bytes shifted in MSB-first (first byte → key[127:120]). The 16th byte → DATA.
  - DATA: 16 bytes, same ordering. The 16th byte → WAIT_READY.
  - WAIT_READY: when `core_ready` = 1, load `key_out`, `data_out` and `enc_dec` from the assembly registers, pulse `start`, then → CMD.
- Outputs change only at launch, so they are stable while the core runs.
- `busy` = 1 in KEY, DATA and WAIT_READY, including the cycle `start` is high.
- Errors, each of which sets `frame_err`:
  - `ferr` in KEY or DATA → abort to CMD.
  - `byte_valid` in WAIT_READY (overrun) → byte dropped, launch still proceeds.
  - Inter-byte gap exceeding `TIMEOUT_CLKS` in KEY or DATA → abort to CMD.
- `ferr` while in CMD also sets `frame_err`.
- Timeout counter: resets on every `byte_valid`, counts only in KEY and DATA, and saturates.

## Timing

- `byte_valid` is asserted one cycle after the mid-stop-bit sample.
- Consuming the last DATA byte: the frame FSM enters WAIT_READY on the edge after `byte_valid`.
- `start` and the new operands appear on the edge after a cycle in WAIT_READY with `core_ready` = 1. With ready already high, `start` rises 2 clocks after `byte_valid`.
- `start` is high for exactly 1 cycle per complete frame, never more.
- Simultaneous events:
  - Timeout and `byte_valid` in the same cycle: the byte wins, so the timeout is not taken.
  - `ferr` and timeout in the same cycle: single abort, `frame_err` = 1.
- End-to-end latency for one frame is 33 bytes × 10 bits × `CLKS_PER_BIT` plus at most 3 clocks, not counting any wait on `core_ready`.

## Test plan

Benches run with `CLKS_PER_BIT` = 8 and `TIMEOUT_CLKS` = 2000.

1. 'E' + key 000102030405060708090a0b0c0d0e0f + data 00112233445566778899aabbccddeeff, `core_ready` = 1 → exactly one `start` 2 clocks after the last `byte_valid`. `key_out`/`data_out` equal those values, `enc_dec` = 1, `busy` falls with the pulse.
2. 'D' + key 2b7e151628aed2a6abf7158809cf4f3c + data 3243f6a8885a308d313198a2e0370734, `core_ready` held 0 for 200 clocks → no `start`, `busy` = 1, outputs unchanged. Raise `core_ready` → one `start` on the next edge, `enc_dec` = 0.
3. Low stop bit on the 5th key byte → `frame_err` = 1, back in CMD, `busy` = 0. A following valid 'E' frame clears `frame_err` at the command byte and launches normally.
4. Bytes 0x00, 0x41, 0xFF, then a valid 'E' frame → junk ignored, `frame_err` stays 0, a single `start` with correct operands.
5. Two cases:
   - A 2-clock low glitch on idle `uart_rx` → no byte, no state change.
   - 'E' + 3 key bytes, then silence for 2001 clocks → `frame_err` = 1, FSM back in CMD, no `start`.
6. Assert `rst_n` low asynchronously mid-DATA → all outputs take reset values without waiting for a clock edge. After release, a full frame launches correctly with no residue from the aborted frame.
